// File: rtl/bsg_hash_bank_sched_pkg.sv
// Shared types and hash helpers for the hashed bank scheduler.
// Address splits as {index, bank}; bank is the low lg(banks) bits.
package bsg_hash_bank_sched_pkg;

  localparam int unsigned MaxAddrW = 64;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } bank_state_e;

  function automatic logic [MaxAddrW-1:0] hash_index(
    input logic [MaxAddrW-1:0] addr,
    input int unsigned         lg_banks
  );
    return addr >> lg_banks;
  endfunction

  function automatic logic [MaxAddrW-1:0] hash_bank(
    input logic [MaxAddrW-1:0] addr,
    input int unsigned         lg_banks
  );
    return addr & ~({MaxAddrW{1'b1}} << lg_banks);
  endfunction

endpackage

// File: rtl/bsg_hash_bank_rr_arb.sv
// Per-bank round-robin arbiter; the search starts at ptr_q and wraps.
// ptr_q advances past the winner only when a grant is issued.
module bsg_hash_bank_rr_arb #(
  parameter  int num_req_p = 4,
  localparam int lg_req_lp = $clog2(num_req_p)
) (
  input  logic                 clk_i,
  input  logic                 reset_n_i,
  input  logic [num_req_p-1:0] cand_i,
  input  logic                 en_i,
  output logic [num_req_p-1:0] grant_o,
  output logic [lg_req_lp-1:0] id_o,
  output logic                 v_o
);

  localparam int W = lg_req_lp + 1;

  logic [lg_req_lp-1:0] ptr_q, ptr_d;
  logic [W-1:0]         j;

  always_comb begin
    grant_o = '0;
    id_o    = '0;
    v_o     = 1'b0;
    ptr_d   = ptr_q;
    j       = '0;
    for (int i = 0; i < num_req_p; i++) begin
      j = {1'b0, ptr_q} + W'(i);
      if (j >= W'(num_req_p))
        j = j - W'(num_req_p);
      if (en_i && !v_o && cand_i[j[lg_req_lp-1:0]]) begin
        v_o                        = 1'b1;
        grant_o[j[lg_req_lp-1:0]]  = 1'b1;
        id_o                       = j[lg_req_lp-1:0];
        if (j == W'(num_req_p - 1))
          ptr_d = '0;
        else
          ptr_d = j[lg_req_lp-1:0] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) ptr_q <= '0;
    else            ptr_q <= ptr_d;
  end

endmodule

// File: rtl/bsg_hash_bank_sched.sv
// Shares hashed banks between requesters: per-bank RR arbiter
// feeding a one-entry output slot with valid/ready drain.
module bsg_hash_bank_sched
  import bsg_hash_bank_sched_pkg::*;
#(
  parameter  int num_req_p      = 4,
  parameter  int banks_p        = 2,
  parameter  int addr_width_p   = 32,
  localparam int lg_banks_lp    = $clog2(banks_p),
  localparam int lg_req_lp      = $clog2(num_req_p),
  localparam int index_width_lp = addr_width_p - lg_banks_lp
) (
  input  logic                                     clk_i,
  input  logic                                     reset_n_i,
  input  logic [num_req_p-1:0]                     v_i,
  input  logic [num_req_p-1:0][addr_width_p-1:0]   addr_i,
  output logic [num_req_p-1:0]                     yumi_o,
  output logic [banks_p-1:0]                       bank_v_o,
  output logic [banks_p-1:0][index_width_lp-1:0]   bank_index_o,
  output logic [banks_p-1:0][lg_req_lp-1:0]        bank_req_id_o,
  input  logic [banks_p-1:0]                       bank_ready_i
);

  typedef struct packed {
    logic                      v;
    logic [index_width_lp-1:0] index;
    logic [lg_req_lp-1:0]      req_id;
  } slot_t;

  logic [num_req_p-1:0][lg_banks_lp-1:0]    req_bank;
  logic [num_req_p-1:0][index_width_lp-1:0] req_index;
  logic [banks_p-1:0][num_req_p-1:0]        cand;
  logic [banks_p-1:0][num_req_p-1:0]        grant;
  logic [banks_p-1:0][lg_req_lp-1:0]        win_id;
  logic [banks_p-1:0]                       win_v;
  logic [banks_p-1:0]                       accept;

  always_comb begin
    req_bank  = '0;
    req_index = '0;
    for (int r = 0; r < num_req_p; r++) begin
      req_bank[r]  = lg_banks_lp'(
        hash_bank(MaxAddrW'(addr_i[r]), lg_banks_lp));
      req_index[r] = index_width_lp'(
        hash_index(MaxAddrW'(addr_i[r]), lg_banks_lp));
    end
  end

  // Reset gates accept so no yumi escapes while slots are held clear.
  always_comb begin
    cand   = '0;
    accept = '0;
    for (int b = 0; b < banks_p; b++) begin
      accept[b] = reset_n_i & (~bank_v_o[b] | bank_ready_i[b]);
      for (int r = 0; r < num_req_p; r++)
        cand[b][r] = v_i[r] & (req_bank[r] == lg_banks_lp'(b));
    end
  end

  always_comb begin
    yumi_o = '0;
    for (int b = 0; b < banks_p; b++)
      yumi_o = yumi_o | grant[b];
  end

  for (genvar b = 0; b < banks_p; b++) begin : g_bank
    slot_t       slot_q, slot_d;
    bank_state_e state_q;

    bsg_hash_bank_rr_arb #(
      .num_req_p (num_req_p)
    ) u_arb (
      .clk_i     (clk_i),
      .reset_n_i (reset_n_i),
      .cand_i    (cand[b]),
      .en_i      (accept[b]),
      .grant_o   (grant[b]),
      .id_o      (win_id[b]),
      .v_o       (win_v[b])
    );

    assign state_q = bank_state_e'(slot_q.v);

    always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) slot_q <= '0;
      else            slot_q <= slot_d;
    end

    always_comb begin
      slot_d = slot_q;
      unique case (state_q)
        EMPTY: begin
          if (win_v[b])
            slot_d = '{v: 1'b1,
                       index: req_index[win_id[b]],
                       req_id: win_id[b]};
        end
        FULL: begin
          if (win_v[b])
            slot_d = '{v: 1'b1,
                       index: req_index[win_id[b]],
                       req_id: win_id[b]};
          else if (bank_ready_i[b])
            slot_d.v = 1'b0;
        end
      endcase
    end

    assign bank_v_o[b]      = (state_q == FULL);
    assign bank_index_o[b]  = slot_q.index;
    assign bank_req_id_o[b] = slot_q.req_id;
  end

endmodule
